// File: rtl/counter_cmd_seq.sv
// ============================================================================
// Module   : counter_cmd_seq
// Purpose  : Command sequencer for the 4-bit counter. Queues host commands in
//            a FIFO, replays each one on enable/mode/D for its run length with
//            one idle cycle between commands, and keeps rco statistics.
//            Optional macro CMD_SEQ_RCO_STOP_EN: rco ends the running command.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [3:0]       cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             ctr_rco,
    input  logic             clr_stats,
    output logic             ctr_enable,
    output logic [1:0]       ctr_mode,
    output logic [3:0]       ctr_D,
    output logic             busy,
    output logic             cmd_done,
    output logic [7:0]       rco_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   c_full_cnt  = (PTR_W+1)'(DEPTH);
    localparam logic [1:0]       c_mode_load = 2'b11;
    localparam logic [7:0]       c_rco_sat   = 8'hFF;
    localparam logic [LEN_W-1:0] c_len_one   = LEN_W'(1);

    typedef struct packed {
        logic [1:0]       mode;
        logic [3:0]       data;
        logic [LEN_W-1:0] len;
    } entry_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             ctr_enable_q, ctr_enable_d;
    logic [1:0]       ctr_mode_q, ctr_mode_d;
    logic [3:0]       ctr_d_q, ctr_d_d;
    logic [7:0]       rco_count_q, rco_count_d;

    logic             w_push;
    logic             w_pop;
    logic             w_last;
    logic             w_done;
    entry_t           w_head;
    entry_t           w_new;

    assign cmd_ready = (count_q != c_full_cnt);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_head    = mem_q[rd_ptr_q];
    assign w_new     = '{mode: cmd_mode, data: cmd_data, len: cmd_len};

`ifdef CMD_SEQ_RCO_STOP_EN
    // A returned ripple carry cuts the command short; loads are single-cycle anyway.
    assign w_last = (rem_q == c_len_one) || (ctr_rco && (ctr_mode_q != c_mode_load));
`else
    assign w_last = (rem_q == c_len_one);
`endif

    // ------------------------------------------------------------------
    // FIFO next state
    // ------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = w_new;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        ctr_enable_d = ctr_enable_q;
        ctr_mode_d   = ctr_mode_q;
        ctr_d_d      = ctr_d_q;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    w_pop        = 1'b1;
                    state_d      = ST_RUN;
                    ctr_enable_d = 1'b1;
                    ctr_mode_d   = w_head.mode;
                    ctr_d_d      = w_head.data;
                    // A zero length still runs one cycle; a load never runs longer.
                    if ((w_head.mode == c_mode_load) || (w_head.len == '0)) begin
                        rem_d = c_len_one;
                    end else begin
                        rem_d = w_head.len;
                    end
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_done       = 1'b1;
                    state_d      = ST_IDLE;
                    ctr_enable_d = 1'b0;
                end else begin
                    rem_d = rem_q - c_len_one;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                ctr_enable_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // rco statistics: clear has priority, count saturates
    // ------------------------------------------------------------------
    always_comb begin
        rco_count_d = rco_count_q;
        if (clr_stats) begin
            rco_count_d = '0;
        end else if (ctr_rco && ctr_enable_q && (rco_count_q != c_rco_sat)) begin
            rco_count_d = rco_count_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            ctr_enable_q <= 1'b0;
            ctr_mode_q   <= 2'b00;
            ctr_d_q      <= 4'h0;
            rco_count_q  <= 8'h00;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            rem_q        <= rem_d;
            ctr_enable_q <= ctr_enable_d;
            ctr_mode_q   <= ctr_mode_d;
            ctr_d_q      <= ctr_d_d;
            rco_count_q  <= rco_count_d;
        end
    end

    assign ctr_enable = ctr_enable_q;
    assign ctr_mode   = ctr_mode_q;
    assign ctr_D      = ctr_d_q;
    assign busy       = (state_q == ST_RUN);
    assign cmd_done   = w_done;
    assign rco_count  = rco_count_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_cmd_seq.sv
// ============================================================================
// Module   : tb_counter_cmd_seq
// Purpose  : Self-checking bench for counter_cmd_seq (vector table, scoreboard
//            of expected command runs, hand-written multi-cycle sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_cmd_seq;

`ifdef CMD_SEQ_RCO_STOP_EN
    localparam bit c_stop = 1'b1;
`else
    localparam bit c_stop = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_data;
    logic [7:0] cmd_len;
    logic       ctr_rco;
    logic       clr_stats;
    logic       ctr_enable;
    logic [1:0] ctr_mode;
    logic [3:0] ctr_D;
    logic       busy;
    logic       cmd_done;
    logic [7:0] rco_count;

    counter_cmd_seq #(.DEPTH(4), .LEN_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_data   (cmd_data),
        .cmd_len    (cmd_len),
        .ctr_rco    (ctr_rco),
        .clr_stats  (clr_stats),
        .ctr_enable (ctr_enable),
        .ctr_mode   (ctr_mode),
        .ctr_D      (ctr_D),
        .busy       (busy),
        .cmd_done   (cmd_done),
        .rco_count  (rco_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] data;
        int         len;
    } sb_t;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] data;
        logic [7:0] len;
        int         rco_at;
        int         exp_len;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[7];
    int   checks;
    int   errors;
    int   cur_exp_len;

    logic       in_run;
    int         run_len;
    logic [1:0] run_mode;
    logic [3:0] run_d;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; an accepted command queues its expected run.
    task automatic tick();
        if (cmd_valid && cmd_ready) begin
            sb.push_back('{cmd_mode, cmd_data, cur_exp_len});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (((sb.size() != 0) || ctr_enable) && (g < 3000)) begin
            tick();
            g++;
        end
        chk("drain_in_time", int'(g < 3000), 1);
        tick();
    endtask

    task automatic push_one(input logic [1:0] m, input logic [3:0] d, input logic [7:0] l, input int el);
        cmd_mode    = m;
        cmd_data    = d;
        cmd_len     = l;
        cur_exp_len = el;
        cmd_valid   = 1'b1;
        tick();
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_enable();
        int g;
        g = 0;
        while (!ctr_enable && (g < 50)) begin
            tick();
            g++;
        end
        chk("enable_in_time", int'(g < 50), 1);
    endtask

    // Run monitor: each completed command is compared against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            in_run = 1'b0;
        end else begin
            chk("busy_eq_enable", int'(busy), int'(ctr_enable));
            chk("done_without_enable", int'(cmd_done & ~ctr_enable), 0);
            if (ctr_enable) begin
                if (!in_run) begin
                    in_run   = 1'b1;
                    run_len  = 0;
                    run_mode = ctr_mode;
                    run_d    = ctr_D;
                end
                run_len++;
                if (cmd_done) begin
                    sb_t e;
                    in_run = 1'b0;
                    chk("sb_has_entry", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("run_len", run_len, e.len);
                        chk("run_mode", int'(run_mode), int'(e.mode));
                        chk("run_D", int'(run_d), int'(e.data));
                    end
                end
            end else if (in_run) begin
                chk("run_ended_with_done", int'(in_run), 0);
                in_run = 1'b0;
            end
        end
    end

    logic en_pat   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic done_pat [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int k;
        int n;
        checks      = 0;
        errors      = 0;
        cur_exp_len = 0;
        in_run      = 1'b0;
        reset       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_mode    = 2'b00;
        cmd_data    = 4'h0;
        cmd_len     = 8'h00;
        ctr_rco     = 1'b0;
        clr_stats   = 1'b0;

        vecs[0] = '{2'b10, 4'd0,  8'd5,   0,  5};
        vecs[1] = '{2'b01, 4'd3,  8'd0,   0,  1};
        vecs[2] = '{2'b11, 4'd9,  8'd7,   0,  1};
        vecs[3] = '{2'b00, 4'd15, 8'd3,   2,  c_stop ? 2 : 3};
        vecs[4] = '{2'b10, 4'd6,  8'd50,  16, c_stop ? 16 : 50};
        vecs[5] = '{2'b10, 4'd2,  8'd255, 0,  255};
        vecs[6] = '{2'b11, 4'd5,  8'd0,   1,  1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_enable", int'(ctr_enable), 0);
        chk("rst_mode", int'(ctr_mode), 0);
        chk("rst_D", int'(ctr_D), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(cmd_done), 0);
        chk("rst_rco_count", int'(rco_count), 0);
        reset = 1'b1;
        tick();
        tick();
        chk("post_rst_enable", int'(ctr_enable), 0);

        // Single commands from the vector table
        for (int i = 0; i < 7; i++) begin
            push_one(vecs[i].mode, vecs[i].data, vecs[i].len, vecs[i].exp_len);
            chk($sformatf("vec%0d_lat_edge1", i), int'(ctr_enable), 0);
            tick();
            chk($sformatf("vec%0d_lat_edge2", i), int'(ctr_enable), 1);
            k = 1;
            while (ctr_enable && (k < 400)) begin
                ctr_rco = (k == vecs[i].rco_at);
                tick();
                k++;
            end
            ctr_rco = 1'b0;
            chk($sformatf("vec%0d_enable_cycles", i), k - 1, vecs[i].exp_len);
            tick();
        end

        // Back-to-back: load command then a 3-cycle mode-01 command
        push_one(2'b11, 4'd9, 8'd7, 1);
        chk("b2b_edge0_enable", int'(ctr_enable), 0);
        push_one(2'b01, 4'd4, 8'd3, 3);
        chk("b2b_load_enable", int'(ctr_enable), 1);
        chk("b2b_load_mode", int'(ctr_mode), 3);
        chk("b2b_load_D", int'(ctr_D), 9);
        chk("b2b_load_done", int'(cmd_done), 1);
        for (int j = 0; j < 5; j++) begin
            tick();
            chk($sformatf("b2b_enable_%0d", j), int'(ctr_enable), int'(en_pat[j]));
            chk($sformatf("b2b_done_%0d", j), int'(cmd_done), int'(done_pat[j]));
            if (j == 1) chk("b2b_second_mode", int'(ctr_mode), 1);
        end
        drain();

        // FIFO full behind a long command
        push_one(2'b10, 4'd1, 8'd200, 200);
        tick();
        chk("full_long_running", int'(ctr_enable), 1);
        for (int j = 0; j < 4; j++) begin
            push_one(2'b01, 4'(j), 8'd1, 1);
        end
        chk("full_ready_low", int'(cmd_ready), 0);
        cmd_mode    = 2'b10;
        cmd_data    = 4'd7;
        cmd_len     = 8'd2;
        cur_exp_len = 2;
        cmd_valid   = 1'b1;
        n = 4;
        while (!cmd_ready && (n < 500)) begin
            tick();
            n++;
        end
        chk("full_ready_rise_cycle", n, 201);
        chk("full_ready_rise_enable", int'(ctr_enable), 1);
        tick();
        cmd_valid = 1'b0;
        drain();

        // rco statistics: saturation under a continuous stream of load commands
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("rco_clear", int'(rco_count), 0);
        cmd_mode    = 2'b11;
        cur_exp_len = 1;
        cmd_valid   = 1'b1;
        ctr_rco     = 1'b1;
        for (int i = 0; i < 700; i++) begin
            cmd_data = 4'(i);
            cmd_len  = 8'($urandom);
            tick();
        end
        cmd_valid = 1'b0;
        drain();
        ctr_rco = 1'b0;
        chk("rco_saturate", int'(rco_count), 255);

        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("rco_clear2", int'(rco_count), 0);
        push_one(2'b11, 4'd2, 8'd0, 1);
        wait_enable();
        ctr_rco   = 1'b1;
        clr_stats = 1'b1;
        tick();
        ctr_rco   = 1'b0;
        clr_stats = 1'b0;
        chk("rco_clear_wins", int'(rco_count), 0);
        drain();
        push_one(2'b11, 4'd3, 8'd0, 1);
        wait_enable();
        ctr_rco = 1'b1;
        tick();
        ctr_rco = 1'b0;
        chk("rco_increment", int'(rco_count), 1);
        drain();
        ctr_rco = 1'b1;
        repeat (3) tick();
        ctr_rco = 1'b0;
        chk("rco_idle_ignored", int'(rco_count), 1);

        // Reset mid-run with a second command still queued
        push_one(2'b10, 4'd8, 8'd20, 20);
        push_one(2'b01, 4'd1, 8'd3, 3);
        repeat (4) tick();
        chk("mid_rst_running", int'(ctr_enable), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_enable", int'(ctr_enable), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_mode", int'(ctr_mode), 0);
        chk("mid_rst_D", int'(ctr_D), 0);
        chk("mid_rst_done", int'(cmd_done), 0);
        chk("mid_rst_rco_count", int'(rco_count), 0);
        chk("mid_rst_ready", int'(cmd_ready), 1);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) tick();
        chk("post_rst_fifo_empty", int'(ctr_enable), 0);
        chk("post_rst_ready", int'(cmd_ready), 1);

        chk("sb_empty_at_end", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
